// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates MEM-stage loads/stores and IF-stage fetches onto a
// byte-wide RAM bus, one byte per cycle, little-endian.
//
// Optional feature macro: IO_BUFFER_FULL_EN
//   When defined, adds io_buffer_full: write beats addressed at or above
//   IO_BASE stall while it is high, and a finished I/O write inserts one
//   extra idle cycle before the next accept.
//
// Ports:
//   clk_in, rst_in            clock, async active-high reset
//   read_mem, write_mem       MEM load/store request (held until done)
//   mem_addr_to_read          MEM byte address
//   mem_data_to_write         store data, byte k = bits [8k+7:8k]
//   data_len                  1, 2 or 4 bytes (3, 5-7 -> 4, 0 ignored)
//   mem_load_done             one-cycle MEM done pulse
//   mem_ctrl_read_in          assembled load data, zero-filled
//   mem_ctrl_busy_state       bit0 serving MEM, bit1 serving IF
//   if_read, if_addr          fetch request and address
//   jump_flush                cancels an in-flight fetch
//   if_done, if_inst          one-cycle fetch done pulse and fetched word
//   io_buffer_full            (IO_BUFFER_FULL_EN only) I/O write back-pressure
//   mem_din                   RAM read data, valid one cycle after mem_a
//   mem_dout, mem_a, mem_wr   RAM write data, address, write enable
module mem_ctrl #(
    parameter logic [31:0] IO_BASE   = 32'h30000,
    parameter int unsigned FETCH_LEN = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        read_mem,
    input  logic        write_mem,
    input  logic [31:0] mem_addr_to_read,
    input  logic [31:0] mem_data_to_write,
    input  logic [2:0]  data_len,
    output logic        mem_load_done,
    output logic [31:0] mem_ctrl_read_in,
    output logic [1:0]  mem_ctrl_busy_state,
    input  logic        if_read,
    input  logic [31:0] if_addr,
    input  logic        jump_flush,
    output logic        if_done,
    output logic [31:0] if_inst,
`ifdef IO_BUFFER_FULL_EN
    input  logic        io_buffer_full,
`endif
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {IDLE, MEM_RD, MEM_WR, IF_RD, DONE} state_t;

    state_t           state_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      buf_q;
    logic [CNT_W-1:0] len_q;
    // Reads: edges seen since accept minus one. Writes: beats issued so far.
    logic [CNT_W-1:0] cnt_q;

    logic [CNT_W-1:0] req_len_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic [31:0]      beat_addr_c;
    logic [31:0]      next_rd_addr_c;
    logic [7:0]       wr_byte_c;
    logic [1:0]       cap_idx_c;
    logic [31:0]      buf_cap_c;
    logic             io_full_c;
    logic             start_stall_c;
    logic             beat_stall_c;
    logic             accept_ok_c;

    // Normalise requested length; 0 means "no transfer"
    always_comb begin
        req_len_c = 3'd4;
        case (data_len)
            3'd0:    req_len_c = 3'd0;
            3'd1:    req_len_c = 3'd1;
            3'd2:    req_len_c = 3'd2;
            default: req_len_c = 3'd4;
        endcase
    end

    assign cnt_inc_c      = cnt_q + 3'd1;
    assign beat_addr_c    = addr_q + 32'(cnt_q);
    assign next_rd_addr_c = beat_addr_c + 32'd1;
    assign wr_byte_c      = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    // Byte arriving on mem_din belongs to the address issued two edges ago
    assign cap_idx_c      = 2'(cnt_q - 3'd1);

    always_comb begin
        buf_cap_c = buf_q;
        buf_cap_c[{cap_idx_c, 3'b000} +: 8] = mem_din;
    end

`ifdef IO_BUFFER_FULL_EN
    logic io_q;
    logic hold_q;
    assign io_full_c   = io_buffer_full;
    assign accept_ok_c = !hold_q;
`else
    assign io_full_c   = 1'b0;
    assign accept_ok_c = 1'b1;
`endif

    assign start_stall_c = io_full_c && (mem_addr_to_read >= IO_BASE);
    assign beat_stall_c  = io_full_c && (beat_addr_c >= IO_BASE);

    // Controller FSM with registered bus and handshake outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q             <= IDLE;
            addr_q              <= '0;
            wdata_q             <= '0;
            buf_q               <= '0;
            len_q               <= '0;
            cnt_q               <= '0;
            mem_load_done       <= 1'b0;
            mem_ctrl_read_in    <= '0;
            mem_ctrl_busy_state <= '0;
            if_done             <= 1'b0;
            if_inst             <= '0;
            mem_dout            <= '0;
            mem_a               <= '0;
            mem_wr              <= 1'b0;
`ifdef IO_BUFFER_FULL_EN
            io_q                <= 1'b0;
            hold_q              <= 1'b0;
`endif
        end else begin
            mem_load_done <= 1'b0;
            if_done       <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef IO_BUFFER_FULL_EN
                    hold_q <= 1'b0;
`endif
                    if (!accept_ok_c) begin
                        state_q <= IDLE;
                    end else if (write_mem || read_mem) begin
                        // A zero-length MEM request is ignored, and still blocks IF
                        if (req_len_c != 3'd0) begin
                            addr_q              <= mem_addr_to_read;
                            len_q               <= req_len_c;
                            wdata_q             <= mem_data_to_write;
                            buf_q               <= '0;
                            mem_ctrl_busy_state <= 2'b01;
                            if (write_mem) begin
                                state_q <= MEM_WR;
`ifdef IO_BUFFER_FULL_EN
                                io_q    <= (mem_addr_to_read >= IO_BASE);
`endif
                                if (start_stall_c) begin
                                    mem_wr <= 1'b0;
                                    cnt_q  <= 3'd0;
                                end else begin
                                    mem_wr   <= 1'b1;
                                    mem_a    <= mem_addr_to_read;
                                    mem_dout <= mem_data_to_write[7:0];
                                    cnt_q    <= 3'd1;
                                end
                            end else begin
                                state_q <= MEM_RD;
                                mem_wr  <= 1'b0;
                                mem_a   <= mem_addr_to_read;
                                cnt_q   <= 3'd0;
                            end
                        end
                    end else if (if_read && !jump_flush) begin
                        state_q             <= IF_RD;
                        addr_q              <= if_addr;
                        len_q               <= 3'(FETCH_LEN);
                        buf_q               <= '0;
                        cnt_q               <= 3'd0;
                        mem_wr              <= 1'b0;
                        mem_a               <= if_addr;
                        mem_ctrl_busy_state <= 2'b10;
                    end
                end

                MEM_RD, IF_RD: begin
                    // A flush seen on any fetch edge, including the last, wins
                    if (state_q == IF_RD && jump_flush) begin
                        state_q             <= IDLE;
                        mem_ctrl_busy_state <= 2'b00;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            buf_q <= buf_cap_c;
                        end
                        if (cnt_inc_c < len_q) begin
                            mem_a <= next_rd_addr_c;
                        end
                        if (cnt_q == len_q) begin
                            state_q             <= DONE;
                            mem_ctrl_busy_state <= 2'b00;
                            if (state_q == MEM_RD) begin
                                mem_load_done    <= 1'b1;
                                mem_ctrl_read_in <= buf_cap_c;
                            end else begin
                                if_done <= 1'b1;
                                if_inst <= buf_cap_c;
                            end
                        end
                        cnt_q <= cnt_inc_c;
                    end
                end

                MEM_WR: begin
                    if (cnt_q == len_q) begin
                        mem_wr              <= 1'b0;
                        mem_load_done       <= 1'b1;
                        mem_ctrl_busy_state <= 2'b00;
                        state_q             <= DONE;
                    end else if (beat_stall_c) begin
                        mem_wr <= 1'b0;
                    end else begin
                        mem_wr   <= 1'b1;
                        mem_a    <= beat_addr_c;
                        mem_dout <= wr_byte_c;
                        cnt_q    <= cnt_inc_c;
`ifdef IO_BUFFER_FULL_EN
                        io_q     <= io_q | (beat_addr_c >= IO_BASE);
`endif
                    end
                end

                DONE: begin
                    // Requester drops its request on done, so no accept here
                    state_q <= IDLE;
`ifdef IO_BUFFER_FULL_EN
                    hold_q  <= io_q;
`endif
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: drivers push expected done/data/beat records,
// a negedge monitor pops and compares them; a byte-array reference memory
// supplies expected load/fetch data.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        read_mem, write_mem;
    logic [31:0] mem_addr_to_read, mem_data_to_write;
    logic [2:0]  data_len;
    logic        mem_load_done;
    logic [31:0] mem_ctrl_read_in;
    logic [1:0]  mem_ctrl_busy_state;
    logic        if_read;
    logic [31:0] if_addr;
    logic        jump_flush;
    logic        if_done;
    logic [31:0] if_inst;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
`ifdef IO_BUFFER_FULL_EN
    logic        io_buffer_full;
`endif

    mem_ctrl dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .read_mem            (read_mem),
        .write_mem           (write_mem),
        .mem_addr_to_read    (mem_addr_to_read),
        .mem_data_to_write   (mem_data_to_write),
        .data_len            (data_len),
        .mem_load_done       (mem_load_done),
        .mem_ctrl_read_in    (mem_ctrl_read_in),
        .mem_ctrl_busy_state (mem_ctrl_busy_state),
        .if_read             (if_read),
        .if_addr             (if_addr),
        .jump_flush          (jump_flush),
        .if_done             (if_done),
        .if_inst             (if_inst),
`ifdef IO_BUFFER_FULL_EN
        .io_buffer_full      (io_buffer_full),
`endif
        .mem_din             (mem_din),
        .mem_dout            (mem_dout),
        .mem_a               (mem_a),
        .mem_wr              (mem_wr)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { logic [31:0] data; int cyc; bit chk_data; } exp_t;
    typedef struct { logic [31:0] addr; logic [7:0] data; } beat_t;

    exp_t  mem_exp[$];
    exp_t  if_exp[$];
    beat_t beat_exp[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int extra_idle = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input logic [9:0] i);
        return (i[7:0] * 8'd13) ^ {6'd0, i[9:8]} ^ 8'hA5;
    endfunction

    // Physical RAM: unwritten bytes read back as init_byte
    logic [7:0] ram [1024];
    bit         ram_vld [1024];
    always @(posedge clk_in) begin
        mem_din <= ram_vld[mem_a[9:0]] ? ram[mem_a[9:0]] : init_byte(mem_a[9:0]);
        if (mem_wr) begin
            ram[mem_a[9:0]]     <= mem_dout;
            ram_vld[mem_a[9:0]] <= 1'b1;
        end
    end

    // Reference memory, updated when a store is issued
    logic [7:0] ref_mem [1024];

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = ref_mem[10'(a + 32'(k))];
        return r;
    endfunction

    function automatic int norm_len(input logic [2:0] l);
        if (l == 3'd1) return 1;
        if (l == 3'd2) return 2;
        return 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a response
    always @(negedge clk_in) begin
        exp_t  e;
        beat_t b;
        if (mem_load_done) begin
            if (mem_exp.size() == 0) fail_now("unexpected_mem_done");
            else begin
                e = mem_exp.pop_front();
                check("mem_done_cycle", 32'(cyc), 32'(e.cyc));
                if (e.chk_data) check("mem_load_data", mem_ctrl_read_in, e.data);
            end
        end
        if (if_done) begin
            if (if_exp.size() == 0) fail_now("unexpected_if_done");
            else begin
                e = if_exp.pop_front();
                check("if_done_cycle", 32'(cyc), 32'(e.cyc));
                check("if_inst", if_inst, e.data);
            end
        end
        if (mem_wr) begin
            if (beat_exp.size() == 0) fail_now("unexpected_write_beat");
            else begin
                b = beat_exp.pop_front();
                check("beat_addr", mem_a, b.addr);
                check("beat_data", {24'd0, mem_dout}, {24'd0, b.data});
            end
        end
    end

    task automatic wait_done(input bit is_if, input logic [1:0] busy_exp, input int e0,
                             input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_in);
            if ((is_if ? if_done : mem_load_done) == 1'b1) begin
                got = 1'b1;
                check({name, "_busy_at_done"}, 32'(mem_ctrl_busy_state), 32'd0);
            end else if (cyc >= e0) begin
                check({name, "_busy"}, 32'(mem_ctrl_busy_state), 32'(busy_exp));
            end
        end
        if (!got) fail_now({name, "_timeout"});
    endtask

    task automatic mem_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] len);
        int   n;
        int   e0;
        bit   io_touch;
        exp_t e;
        @(negedge clk_in);
        n  = norm_len(len);
        e0 = cyc + 1 + extra_idle;
        extra_idle = 0;
        io_touch = 1'b0;
        write_mem = wr; read_mem = !wr;
        mem_addr_to_read = a; mem_data_to_write = d; data_len = len;
        e.chk_data = !wr;
        if (wr) begin
            e.cyc  = e0 + n;
            e.data = '0;
            for (int k = 0; k < n; k++) begin
                beat_exp.push_back('{a + 32'(k), d[8*k +: 8]});
                ref_mem[10'(a + 32'(k))] = d[8*k +: 8];
`ifdef IO_BUFFER_FULL_EN
                if ((a + 32'(k)) >= 32'h30000) io_touch = 1'b1;
`endif
            end
        end else begin
            e.cyc  = e0 + n + 1;
            e.data = ref_read(a, n);
        end
        mem_exp.push_back(e);
        wait_done(1'b0, 2'b01, e0, wr ? "store" : "load");
        write_mem = 1'b0; read_mem = 1'b0;
        extra_idle = int'(io_touch);
    endtask

    task automatic if_txn(input logic [31:0] a);
        int   e0;
        exp_t e;
        @(negedge clk_in);
        e0 = cyc + 1 + extra_idle;
        extra_idle = 0;
        if_read = 1'b1; if_addr = a;
        e.chk_data = 1'b1;
        e.cyc  = e0 + 5;
        e.data = ref_read(a, 4);
        if_exp.push_back(e);
        wait_done(1'b1, 2'b10, e0, "fetch");
        if_read = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string name);
        check({name, "_mem_a"}, mem_a, 32'd0);
        check({name, "_mem_wr"}, 32'(mem_wr), 32'd0);
        check({name, "_mem_dout"}, 32'(mem_dout), 32'd0);
        check({name, "_busy"}, 32'(mem_ctrl_busy_state), 32'd0);
        check({name, "_load_done"}, 32'(mem_load_done), 32'd0);
        check({name, "_if_done"}, 32'(if_done), 32'd0);
        check({name, "_read_in"}, mem_ctrl_read_in, 32'd0);
        check({name, "_if_inst"}, if_inst, 32'd0);
    endtask

    int          e0;
    int          mism;
    int          kind;
    logic [31:0] ra, rd;
    logic [2:0]  rl;
    logic [7:0]  v;
    exp_t        ex;

    initial begin
        #200000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1;
        read_mem = 1'b0; write_mem = 1'b0; mem_addr_to_read = '0; mem_data_to_write = '0;
        data_len = '0; if_read = 1'b0; if_addr = '0; jump_flush = 1'b0;
`ifdef IO_BUFFER_FULL_EN
        io_buffer_full = 1'b0;
`endif
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(10'(i));
        repeat (3) @(negedge clk_in);
        chk_outputs_zero("reset");
        rst_in = 1'b0;

        // SW then LW at 0x100: bytes 11 22 33 44
        mem_txn(1'b1, 32'h100, 32'h44332211, 3'd4);
        mem_txn(1'b0, 32'h100, 32'h0, 3'd4);
        check("lw_0x100_value", mem_ctrl_read_in, 32'h44332211);

        // SH 0xBEEF at 0x204; 0x206 must stay unwritten
        mem_txn(1'b1, 32'h204, 32'h0000BEEF, 3'd2);
        check("sh_0x206_untouched", 32'(ram_vld[10'h206]), 32'd0);

        // LB and fetch requested together: MEM first, fetch in the next IDLE
        @(negedge clk_in);
        e0 = cyc + 1;
        read_mem = 1'b1; mem_addr_to_read = 32'h10; data_len = 3'd1;
        if_read = 1'b1; if_addr = 32'h0;
        ex.chk_data = 1'b1; ex.cyc = e0 + 2; ex.data = ref_read(32'h10, 1);
        mem_exp.push_back(ex);
        ex.cyc = e0 + 9; ex.data = ref_read(32'h0, 4);
        if_exp.push_back(ex);
        wait_done(1'b0, 2'b01, e0, "lb_first");
        read_mem = 1'b0;
        wait_done(1'b1, 2'b10, e0 + 4, "fetch_second");
        if_read = 1'b0;

        // Fetch flushed in cycle 3: no if_done, busy cleared
        @(negedge clk_in);
        if_read = 1'b1; if_addr = 32'h80;
        repeat (3) @(negedge clk_in);
        jump_flush = 1'b1; if_read = 1'b0;
        @(negedge clk_in);
        check("flush_busy", 32'(mem_ctrl_busy_state), 32'd0);
        check("flush_no_if_done", 32'(if_done), 32'd0);
        jump_flush = 1'b0;
        if_txn(32'h40);

        // Reset in cycle 2 of an SW: only byte 0 reaches RAM
        @(negedge clk_in);
        write_mem = 1'b1; mem_addr_to_read = 32'h300; mem_data_to_write = 32'hA1B2C3D4;
        data_len = 3'd4;
        beat_exp.push_back('{32'h300, 8'hD4});
        beat_exp.push_back('{32'h301, 8'hC3});
        ref_mem[10'h300] = 8'hD4;
        repeat (2) @(negedge clk_in);
        #2;
        rst_in = 1'b1; write_mem = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        @(negedge clk_in);
        rst_in = 1'b0;
        mem_txn(1'b0, 32'h300, 32'h0, 3'd4);

        // Zero-length request is ignored
        @(negedge clk_in);
        read_mem = 1'b1; mem_addr_to_read = 32'h20; data_len = 3'd0;
        repeat (3) begin
            @(negedge clk_in);
            check("len0_busy", 32'(mem_ctrl_busy_state), 32'd0);
        end
        read_mem = 1'b0;

`ifdef IO_BUFFER_FULL_EN
        // SB to I/O space with buffer full for 3 cycles, then a load
        @(negedge clk_in);
        e0 = cyc + 1;
        write_mem = 1'b1; mem_addr_to_read = 32'h30000; mem_data_to_write = 32'h5C;
        data_len = 3'd1; io_buffer_full = 1'b1;
        beat_exp.push_back('{32'h30000, 8'h5C});
        ref_mem[10'h000] = 8'h5C;
        ex.chk_data = 1'b0; ex.cyc = e0 + 4; ex.data = '0;
        mem_exp.push_back(ex);
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk_in);
            check("io_stall_wr", 32'(mem_wr), 32'd0);
            if (j == 3) io_buffer_full = 1'b0;
        end
        wait_done(1'b0, 2'b01, e0, "io_store");
        write_mem = 1'b0;
        extra_idle = 1;
        mem_txn(1'b0, 32'h30000, 32'h0, 3'd1);
`endif

        // Random mix, including 32-bit address wrap and odd lengths
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            ra = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 1023));
            rl = 3'($urandom_range(1, 7));
            rd = $urandom;
            case (kind)
                0:       mem_txn(1'b0, ra, rd, rl);
                1:       mem_txn(1'b1, ra, rd, rl);
                default: if_txn(ra);
            endcase
        end

        repeat (3) @(negedge clk_in);
        mism = 0;
        for (int i = 0; i < 1024; i++) begin
            v = ram_vld[i] ? ram[i] : init_byte(10'(i));
            if (v !== ref_mem[i]) mism++;
        end
        check("ram_image_mismatches", 32'(mism), 32'd0);
        check("pending_expectations", 32'(mem_exp.size() + if_exp.size() + beat_exp.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller sitting directly downstream of the MEM stage and the IF stage.
- Arbitrates between data requests (load/store, 1/2/4 bytes) and instruction fetches (always 4 bytes).
- Serialises each request onto the byte-wide RAM bus.
- Returns assembled little-endian data with a one-cycle done pulse and publishes a busy state the MEM stage uses to hold off.

Parameters:
- IO_BASE, 32'h30000: addresses >= IO_BASE are I/O-mapped (used only by the optional feature).
- FETCH_LEN, 4: bytes per instruction fetch.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-high reset
- read_mem  in  1  MEM load request, held until mem_load_done
- write_mem  in  1  MEM store request, held until mem_load_done
- mem_addr_to_read  in  32  MEM byte address (loads and stores)
- mem_data_to_write  in  32  store data; byte k = bits [8k+7:8k]
- data_len  in  3  bytes to transfer: 1, 2 or 4
- mem_load_done  out  1  one-cycle done pulse for a MEM load or store
- mem_ctrl_read_in  out  32  assembled load data, zero-filled above data_len
- mem_ctrl_busy_state  out  2  bit0 = serving MEM, bit1 = serving IF
- if_read  in  1  fetch request, held until if_done
- if_addr  in  32  fetch address
- jump_flush  in  1  cancel any in-flight fetch
- if_done  out  1  one-cycle fetch done pulse
- if_inst  out  32  fetched word
- mem_din  in  8  RAM read data; valid one cycle after mem_a
- mem_dout  out  8  RAM write data
- mem_a  out  32  RAM address
- mem_wr  out  1  1 = write, 0 = read

Behaviour:
- Reset (async): state IDLE; all outputs 0, including mem_a, mem_dout, mem_wr, done pulses, data outputs and busy_state.
- All outputs are registered.
- States: IDLE, MEM_RD, MEM_WR, IF_RD, DONE.
- IDLE, sampling edge E0:
  - write_mem -> MEM_WR.
  - else read_mem -> MEM_RD.
  - else if_read and !jump_flush -> IF_RD.
  - MEM has priority over IF. Address, length and write data are latched at E0.
- Length: data_len 1/2/4 used as-is; 3 or 5-7 treated as 4; 0 with a request active is ignored (stay IDLE).
- busy_state: bit0 = 1 throughout MEM_RD/MEM_WR; bit1 = 1 throughout IF_RD. Both 0 in IDLE and DONE.
- Read of N bytes (MEM_RD, IF_RD):
  - mem_wr = 0; mem_a = A+k during cycle k+1 after E0, for k = 0..N-1.
  - Byte k is captured from mem_din at edge E(k+2) into bits [8k+7:8k].
  - At E(N+1): last byte captured, done pulse set, state -> DONE.
  - Load done is visible N+1 edges after E0 (LW: 5, LB: 2).
- Write of N bytes (MEM_WR):
  - mem_wr = 1, mem_a = A+k, mem_dout = byte k during cycle k+1.
  - At E(N): mem_wr = 0, done set, state -> DONE.
  - Store done is visible N edges after E0.
- DONE:
  - Done pulse lasts exactly one cycle; data output holds its value until the next transaction of that type completes.
  - Next edge -> IDLE with no new accept. The requester drops its request on seeing done, so it is never re-accepted.
- Outside an active write beat: mem_wr = 0 and mem_a is held.
- jump_flush:
  - Asserted during IF_RD: abort to IDLE at the next edge; no if_done; bit1 cleared.
  - Asserted in DONE for an IF transaction: if_done is suppressed.
  - No effect on MEM transactions.
- Simultaneous if_read and read_mem in IDLE: MEM served first. if_read remains pending and is accepted in the IDLE that follows DONE.
- Address arithmetic: 32-bit wrap, A+k mod 2^32.
- rst_in mid-transaction: immediate return to IDLE with no done pulse; partially written bytes stay in RAM.

Optional Feature:
- Macro: IO_BUFFER_FULL_EN
- Defined:
  - Adds input io_buffer_full (1 bit).
  - A MEM_WR beat whose address is >= IO_BASE is not issued while io_buffer_full = 1. mem_wr = 0 and the byte index holds until it clears; each stalled cycle extends done latency by one.
  - After any I/O write completes, DONE is followed by one extra idle cycle before a new accept.
- Undefined: no port; I/O writes are timed like RAM writes.

Test Plan:
- LW at 0x100, RAM bytes 11 22 33 44 -> mem_a 0x100..0x103 in cycles 1-4; mem_load_done high only in cycle 6 (5 edges after E0); mem_ctrl_read_in = 0x44332211; busy_state = 01 during cycles 1-5.
- SH 0x0000BEEF at 0x204 -> mem_wr = 1 with (0x204, EF) then (0x205, BE); done 2 edges after E0; RAM 0x206 untouched.
- read_mem (LB at 0x10) and if_read (0x0) asserted in the same cycle -> LB served first (done after 2 edges, read_in = 0x000000xx); fetch accepted in the following IDLE; if_done 5 edges later, if_inst correct.
- Fetch in flight; jump_flush at cycle 3 -> return to IDLE, no if_done, busy_state[1] = 0 next cycle; new fetch at 0x40 completes normally.
- rst_in pulsed during cycle 2 of an SW -> all outputs 0 immediately; no done pulse; next LW completes with normal 5-edge latency.
- With IO_BUFFER_FULL_EN: SB to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr held 0 for 3 cycles; done 4 edges after E0; one idle cycle before the next accept.
